// File: rtl/crc_tx_sequencer.sv
// Transmit packet sequencer: serializes TXPU payload bytes LSB first to the bit stuffer while
// mirroring accepted bits into the CRC engine, then sends the 16-bit CRC result LSB first.
module crc_tx_sequencer #(
    parameter logic INVERT_CRC  = 1'b1,
    parameter int   CRC_TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pkt_start,
    input  logic        zero_len,
    input  logic        abort,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        byte_last,
    output logic        byte_ready,
    output logic        crc_clear,
    output logic        crc_bit,
    output logic        crc_bit_valid,
    output logic        crc_calc,
    input  logic        crc_done,
    input  logic [15:0] crc_value,
    output logic        tx_bit,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        pkt_done,
    output logic        crc_err
);
    localparam int TW = $clog2(CRC_TIMEOUT) + 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_DATA     = 3'd2;
    localparam logic [2:0] S_CRC_WAIT = 3'd3;
    localparam logic [2:0] S_CRC_TX   = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          last_q, last_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0]   crc_latch_q, crc_latch_d;
    logic          timeout;

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        last_d        = last_q;
        bit_cnt_d     = bit_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        crc_latch_d   = crc_latch_q;
        byte_ready    = 1'b0;
        crc_clear     = 1'b0;
        crc_bit       = 1'b0;
        crc_bit_valid = 1'b0;
        crc_calc      = 1'b0;
        tx_bit        = 1'b0;
        tx_valid      = 1'b0;
        busy          = (state_q != S_IDLE);
        pkt_done      = 1'b0;
        crc_err       = 1'b0;
        timeout       = (tmo_cnt_q == TW'(CRC_TIMEOUT));

        // Abort suppresses every handshake so no partial bit leaks to the stuffer or CRC engine.
        if (state_q != S_IDLE && abort) begin
            state_d   = S_IDLE;
            crc_clear = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Gated by rst so a start pulse during reset emits no clear.
                    if (pkt_start && !abort && !rst) begin
                        crc_clear = 1'b1;
                        tmo_cnt_d = '0;
                        state_d   = zero_len ? S_CRC_WAIT : S_LOAD;
                    end
                end
                S_LOAD: begin
                    byte_ready = 1'b1;
                    if (byte_valid) begin
                        shreg_d   = byte_in;
                        last_d    = byte_last;
                        bit_cnt_d = 5'd0;
                        state_d   = S_DATA;
                    end
                end
                S_DATA: begin
                    tx_valid = 1'b1;
                    tx_bit   = shreg_q[0];
                    crc_bit  = shreg_q[0];
                    if (tx_ready) begin
                        crc_bit_valid = 1'b1;
                        shreg_d       = {1'b0, shreg_q[7:1]};
                        bit_cnt_d     = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            tmo_cnt_d = '0;
                            state_d   = last_q ? S_CRC_WAIT : S_LOAD;
                        end
                    end
                end
                S_CRC_WAIT: begin
                    crc_calc = 1'b1;
                    if (crc_done) begin
                        crc_latch_d = INVERT_CRC ? ~crc_value : crc_value;
                        bit_cnt_d   = 5'd0;
                        state_d     = S_CRC_TX;
                    end else if (timeout) begin
                        crc_err   = 1'b1;
                        crc_clear = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
                S_CRC_TX: begin
                    tx_valid = 1'b1;
                    tx_bit   = crc_latch_q[0];
                    if (tx_ready) begin
                        crc_latch_d = {1'b0, crc_latch_q[15:1]};
                        bit_cnt_d   = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd15) state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    pkt_done = 1'b1;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            last_q      <= 1'b0;
            bit_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            crc_latch_q <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            last_q      <= last_d;
            bit_cnt_q   <= bit_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            crc_latch_q <= crc_latch_d;
        end
    end
endmodule

// File: tb/tb_crc_tx_sequencer.sv
// Bench for crc_tx_sequencer: a byte source, a CRC engine stand-in and a bit-stream monitor
// drive the DUT; expected streams come from the packet bytes and the CRC word directly.
module tb_crc_tx_sequencer;
    localparam logic INV = 1'b1;
    localparam int   TMO = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pkt_start = 1'b0, zero_len = 1'b0, abort = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0, byte_last = 1'b0, byte_ready;
    logic        crc_clear, crc_bit, crc_bit_valid, crc_calc;
    logic        crc_done = 1'b0;
    logic [15:0] crc_value = 16'h0000;
    logic        tx_bit, tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy, pkt_done, crc_err;

    crc_tx_sequencer #(.INVERT_CRC(INV), .CRC_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .pkt_start(pkt_start), .zero_len(zero_len), .abort(abort),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(byte_ready),
        .crc_clear(crc_clear), .crc_bit(crc_bit), .crc_bit_valid(crc_bit_valid), .crc_calc(crc_calc),
        .crc_done(crc_done), .crc_value(crc_value), .tx_bit(tx_bit), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .pkt_done(pkt_done), .crc_err(crc_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int cyc = 0;
    int rdy_pct = 100, crc_delay = 0, crc_wait = 0;
    bit crc_en = 1'b1;
    logic [7:0] pkt_bytes[$];
    logic [7:0] byte_q[$];
    bit byte_taken = 1'b0;
    bit tx_q[$], crc_q[$], exp_q[$];
    int exp_payload_bits;
    int n_pkt_done, n_crc_err, n_clear, n_byte_ready, first_tx_cyc, first_calc_cyc, err_cyc, start_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte source and bit-stuffer readiness
    always @(posedge clk) begin
        #1;
        if (byte_taken) begin
            if (byte_q.size() > 0) byte_q.delete(0);
            byte_taken = 1'b0;
        end
        byte_valid = (byte_q.size() > 0);
        byte_in    = byte_valid ? byte_q[0] : 8'h00;
        byte_last  = (byte_q.size() == 1);
        tx_ready   = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
    end

    // CRC engine stand-in: answers crc_calc after crc_delay cycles
    always @(posedge clk) begin
        #2;
        if (crc_calc && crc_en) begin
            if (crc_wait >= crc_delay) crc_done = 1'b1;
            else begin crc_wait++; crc_done = 1'b0; end
        end else begin
            crc_done = 1'b0;
            crc_wait = 0;
        end
    end

    always @(negedge clk) begin
        if (tx_valid && tx_ready) tx_q.push_back(tx_bit);
        if (crc_bit_valid) crc_q.push_back(crc_bit);
        if (byte_valid && byte_ready) byte_taken = 1'b1;
        if (byte_ready) n_byte_ready++;
        if (pkt_done) n_pkt_done++;
        if (crc_err) begin n_crc_err++; err_cyc = cyc; end
        if (crc_clear) n_clear++;
        if (tx_valid && first_tx_cyc < 0) first_tx_cyc = cyc;
        if (crc_calc && first_calc_cyc < 0) first_calc_cyc = cyc;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        tx_q.delete(); crc_q.delete();
        n_pkt_done = 0; n_crc_err = 0; n_clear = 0; n_byte_ready = 0;
        first_tx_cyc = -1; first_calc_cyc = -1; err_cyc = -1;
    endtask

    // Reference: payload bytes LSB first, then the (optionally inverted) CRC word LSB first.
    task automatic build_exp(input logic [15:0] cv);
        exp_q.delete();
        foreach (pkt_bytes[i])
            for (int k = 0; k < 8; k++) exp_q.push_back(pkt_bytes[i][k]);
        exp_payload_bits = exp_q.size();
        for (int k = 0; k < 16; k++) exp_q.push_back(INV ? ~cv[k] : cv[k]);
    endtask

    task automatic start_packet(input bit zl, input logic [15:0] cv, input int dly, input int pct, input bit en);
        @(posedge clk); #1;
        crc_value = cv; crc_delay = dly; crc_en = en; rdy_pct = pct;
        byte_q.delete();
        if (!zl) byte_q = pkt_bytes;
        clear_mon();
        @(posedge clk); @(posedge clk); #1;
        pkt_start = 1'b1; zero_len = zl; start_cyc = cyc;
        @(posedge clk); #1;
        pkt_start = 1'b0; zero_len = 1'b0;
    endtask

    task automatic run_packet(input bit zl, input logic [15:0] cv, input int dly, input int pct, input string tag);
        int mism;
        if (zl) pkt_bytes.delete();
        build_exp(cv);
        start_packet(zl, cv, dly, pct, 1'b1);
        for (int c = 0; c < 3000 && n_pkt_done == 0 && n_crc_err == 0; c++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (n_pkt_done != 1) $display("FAIL %s pkt_done_count: got %0d want 1", tag, n_pkt_done); else n_pass++;
        n_checks++;
        if (tx_q.size() != exp_q.size()) $display("FAIL %s tx_len: got %0d want %0d", tag, tx_q.size(), exp_q.size()); else n_pass++;
        mism = 0;
        for (int i = 0; i < exp_q.size(); i++) if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) mism++;
        n_checks++;
        if (mism != 0) $display("FAIL %s tx_bits: got %0d wrong bits want 0", tag, mism); else n_pass++;
        n_checks++;
        if (crc_q.size() != exp_payload_bits) $display("FAIL %s crc_bit_count: got %0d want %0d", tag, crc_q.size(), exp_payload_bits); else n_pass++;
        mism = 0;
        for (int i = 0; i < exp_payload_bits; i++) if (i >= crc_q.size() || crc_q[i] !== exp_q[i]) mism++;
        n_checks++;
        if (mism != 0) $display("FAIL %s crc_bits: got %0d wrong bits want 0", tag, mism); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s busy_after: got %b want 0", tag, busy); else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; pkt_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({byte_ready, crc_clear, crc_bit, crc_bit_valid, crc_calc, tx_bit, tx_valid, busy, pkt_done, crc_err} !== 10'b0)
            $display("FAIL reset_outputs: got %b want 0", {byte_ready, crc_clear, crc_bit, crc_bit_valid, crc_calc, tx_bit, tx_valid, busy, pkt_done, crc_err});
        else n_pass++;
        pkt_start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({byte_ready, crc_clear, crc_calc, tx_valid, busy, pkt_done, crc_err} !== 7'b0)
            $display("FAIL idle_outputs: got %b want 0", {byte_ready, crc_clear, crc_calc, tx_valid, busy, pkt_done, crc_err});
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [15:0] w;
        pkt_bytes = '{8'h80, 8'h06};
        run_packet(1'b0, 16'hBB29, 2, 100, "basic");
        w = 16'h0000;
        for (int k = 0; k < 16; k++) if (16 + k < tx_q.size()) w[k] = tx_q[16 + k];
        n_checks++;
        if (w !== 16'h44D6) $display("FAIL basic_crc_word: got %h want 44d6", w); else n_pass++;
        n_checks++;
        if (first_tx_cyc - start_cyc != 2) $display("FAIL basic_latency: got %0d want 2", first_tx_cyc - start_cyc); else n_pass++;
        n_checks++;
        if (n_clear != 1) $display("FAIL basic_clear_count: got %0d want 1", n_clear); else n_pass++;
    endtask

    task automatic test_stall();
        pkt_bytes = '{8'h80, 8'h06};
        run_packet(1'b0, 16'hBB29, 1, 50, "stall");
    endtask

    task automatic test_zero_len();
        run_packet(1'b1, 16'hFFFF, 0, 100, "zero_len");
        n_checks++;
        if (n_byte_ready != 0) $display("FAIL zero_len_byte_ready: got %0d want 0", n_byte_ready); else n_pass++;
        n_checks++;
        if (first_calc_cyc - start_cyc != 1) $display("FAIL zero_len_calc_delay: got %0d want 1", first_calc_cyc - start_cyc); else n_pass++;
    endtask

    task automatic test_random();
        int len;
        for (int p = 0; p < 5; p++) begin
            pkt_bytes.delete();
            len = $urandom_range(5, 1);
            for (int i = 0; i < len; i++) pkt_bytes.push_back(8'($urandom));
            run_packet(1'b0, 16'($urandom), $urandom_range(8), $urandom_range(100, 30), "random");
        end
    endtask

    task automatic test_timeout();
        pkt_bytes = '{8'hA5};
        start_packet(1'b0, 16'h1234, 0, 70, 1'b0);
        for (int c = 0; c < 500 && n_crc_err == 0; c++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (err_cyc - first_calc_cyc != TMO) $display("FAIL timeout_cycles: got %0d want %0d", err_cyc - first_calc_cyc, TMO); else n_pass++;
        n_checks++;
        if (n_crc_err != 1) $display("FAIL timeout_err_count: got %0d want 1", n_crc_err); else n_pass++;
        n_checks++;
        if (n_clear != 2) $display("FAIL timeout_clear_count: got %0d want 2", n_clear); else n_pass++;
        n_checks++;
        if (n_pkt_done != 0 || busy !== 1'b0) $display("FAIL timeout_idle: got done=%0d busy=%b want 0/0", n_pkt_done, busy); else n_pass++;
        crc_en = 1'b1;
    endtask

    task automatic test_abort();
        pkt_bytes = '{8'h3C, 8'hC3, 8'h5A};
        start_packet(1'b0, 16'h0F0F, 0, 100, 1'b1);
        for (int c = 0; c < 200 && tx_q.size() < 11; c++) @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        n_checks++;
        if (crc_clear !== 1'b1 || tx_valid !== 1'b0) $display("FAIL abort_cycle: got clear=%b tx_valid=%b want 1/0", crc_clear, tx_valid); else n_pass++;
        @(posedge clk); #1;
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL abort_idle: got busy=%b want 0", busy); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (n_pkt_done != 0 || tx_q.size() != 11) $display("FAIL abort_dropped: got done=%0d bits=%0d want 0/11", n_pkt_done, tx_q.size()); else n_pass++;
        byte_q.delete();
        pkt_start = 1'b1; abort = 1'b1;
        @(negedge clk);
        n_checks++;
        if (crc_clear !== 1'b0) $display("FAIL abort_start_clear: got %b want 0", crc_clear); else n_pass++;
        @(posedge clk); #1;
        pkt_start = 1'b0; abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL abort_start_idle: got busy=%b want 0", busy); else n_pass++;
        pkt_bytes = '{8'h96, 8'h01};
        run_packet(1'b0, 16'h5AA5, 1, 100, "after_abort");
    endtask

    task automatic test_rst_mid();
        logic was_busy;
        int mism;
        pkt_bytes = '{8'hE7};
        start_packet(1'b0, 16'hC001, 0, 100, 1'b1);
        for (int c = 0; c < 200 && tx_q.size() < 12; c++) @(posedge clk);
        #1;
        was_busy = busy;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({was_busy, byte_ready, crc_clear, crc_bit_valid, crc_calc, tx_bit, tx_valid, busy, pkt_done, crc_err} !== 10'b1000000000)
            $display("FAIL rst_mid_outputs: got %b want 1000000000", {was_busy, byte_ready, crc_clear, crc_bit_valid, crc_calc, tx_bit, tx_valid, busy, pkt_done, crc_err});
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (n_pkt_done != 0 || n_crc_err != 0 || n_clear != 1) $display("FAIL rst_mid_pulses: got done=%0d err=%0d clear=%0d want 0/0/1", n_pkt_done, n_crc_err, n_clear); else n_pass++;

        pkt_bytes = '{8'h4B};
        build_exp(16'h7E81);
        start_packet(1'b0, 16'h7E81, 0, 100, 1'b1);
        for (int c = 0; c < 500 && !pkt_done; c++) begin
            @(posedge clk); #1;
            pkt_start = (tx_q.size() == 3);
        end
        pkt_start = 1'b1;
        @(posedge clk); #1;
        pkt_start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL start_in_done: got busy=%b want 0", busy); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        mism = 0;
        for (int i = 0; i < exp_q.size(); i++) if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) mism++;
        n_checks++;
        if (mism != 0 || tx_q.size() != exp_q.size()) $display("FAIL start_while_busy_stream: got %0d wrong of %0d want 0 of %0d", mism, tx_q.size(), exp_q.size()); else n_pass++;
        n_checks++;
        if (n_clear != 1 || n_pkt_done != 1 || busy !== 1'b0) $display("FAIL start_while_busy_pulses: got clear=%0d done=%0d busy=%b want 1/1/0", n_clear, n_pkt_done, busy); else n_pass++;
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_random();
        test_timeout();
        test_abort();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
